// File: rtl/m32_8.sv
// 32-to-8 serializer for the PCIe PHY transmit path: one 32-bit word in over
// valid/ready, four registered bytes out on consecutive clk_4f cycles.
module m32_8 #(
    parameter bit         MSB_FIRST = 1'b1,
    parameter logic [7:0] IDLE_BYTE = 8'h00
) (
    input  logic        clk_4f,
    input  logic        reset,
    input  logic [31:0] data_input,
    input  logic        valid_input,
    output logic        ready_32_8,
    output logic [7:0]  data_32_8,
    output logic        valid_32_8
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t      state, state_n;
    logic [1:0]  cnt, cnt_n;
    logic [31:0] shift, shift_n;
    logic [31:0] hold, hold_n;
    logic        hold_v, hold_v_n;
    logic [7:0]  data_n;
    logic        valid_n;
    logic        ready_n;
    logic        xfer;
    logic        last;
    logic [1:0]  sel;
    logic [7:0]  cur_byte;

    assign xfer = valid_input && ready_32_8;
    assign last = (state == SEND) && (cnt == 2'd3);
    assign sel  = MSB_FIRST ? ~cnt : cnt;

    always_comb begin
        case (sel)
            2'd0:    cur_byte = shift[7:0];
            2'd1:    cur_byte = shift[15:8];
            2'd2:    cur_byte = shift[23:16];
            default: cur_byte = shift[31:24];
        endcase
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        shift_n  = shift;
        hold_n   = hold;
        hold_v_n = hold_v;
        data_n   = IDLE_BYTE;
        valid_n  = 1'b0;
        case (state)
            IDLE: begin
                if (xfer) begin
                    shift_n = data_input;
                    cnt_n   = 2'd0;
                    state_n = SEND;
                end
            end
            SEND: begin
                data_n  = cur_byte;
                valid_n = 1'b1;
                cnt_n   = cnt + 2'd1;
                if (last) begin
                    // Reload on the last byte keeps the output stream gapless.
                    if (hold_v) begin
                        shift_n  = hold;
                        hold_v_n = 1'b0;
                    end else if (xfer) begin
                        shift_n = data_input;
                    end else begin
                        state_n = IDLE;
                    end
                end else if (xfer) begin
                    hold_n   = data_input;
                    hold_v_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        ready_n = !hold_v_n;
    end

    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= 2'd0;
            shift      <= 32'd0;
            hold       <= 32'd0;
            hold_v     <= 1'b0;
            data_32_8  <= IDLE_BYTE;
            valid_32_8 <= 1'b0;
            ready_32_8 <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            shift      <= shift_n;
            hold       <= hold_n;
            hold_v     <= hold_v_n;
            data_32_8  <= data_n;
            valid_32_8 <= valid_n;
            ready_32_8 <= ready_n;
        end
    end

endmodule

// File: tb/tb_m32_8.sv
// Directed bench for m32_8: an MSB-first and an LSB-first instance share one
// input stream; a bench-side packer reassembles each byte stream into words.
module tb_m32_8;

    logic        clk_4f = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] data_input = 32'd0;
    logic        valid_input = 1'b0;
    logic        ready_m, valid_m, ready_l, valid_l;
    logic [7:0]  data_m, data_l;

    int vec = 0;
    int errs = 0;

    always #5 clk_4f = ~clk_4f;

    m32_8 #(.MSB_FIRST(1'b1), .IDLE_BYTE(8'h00)) dut_m (
        .clk_4f(clk_4f), .reset(reset), .data_input(data_input), .valid_input(valid_input),
        .ready_32_8(ready_m), .data_32_8(data_m), .valid_32_8(valid_m));

    m32_8 #(.MSB_FIRST(1'b0), .IDLE_BYTE(8'h00)) dut_l (
        .clk_4f(clk_4f), .reset(reset), .data_input(data_input), .valid_input(valid_input),
        .ready_32_8(ready_l), .data_32_8(data_l), .valid_32_8(valid_l));

    // Byte log with cycle stamps plus the 8-to-32 packer models.
    int          cyc = 0;
    logic [7:0]  mq[$];
    int          mc[$];
    logic [31:0] pk_m[$], pk_l[$];
    logic [31:0] acc_m = 32'd0, acc_l = 32'd0;
    int          n_m = 0, n_l = 0;

    always begin
        logic [31:0] tm, tl;
        @(posedge clk_4f);
        #2;
        cyc++;
        if (valid_m === 1'b1) begin
            mq.push_back(data_m);
            mc.push_back(cyc);
            tm = {acc_m[23:0], data_m};
            acc_m = tm;
            n_m++;
            if (n_m == 4) begin pk_m.push_back(tm); n_m = 0; end
        end
        if (valid_l === 1'b1) begin
            tl = {data_l, acc_l[31:8]};
            acc_l = tl;
            n_l++;
            if (n_l == 4) begin pk_l.push_back(tl); n_l = 0; end
        end
    end

    task automatic tick;
        @(posedge clk_4f);
        #1;
    endtask

    task automatic clear_mon;
        mq.delete(); mc.delete(); pk_m.delete(); pk_l.delete();
        n_m = 0; n_l = 0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) tick();
        vec++;
        if (data_m !== 8'h00 || valid_m !== 1'b0 || ready_m !== 1'b0) begin
            errs++;
            $display("FAIL reset_state: got data=%h valid=%b ready=%b, want 00/0/0", data_m, valid_m, ready_m);
        end
        data_input = 32'hCAFEF00D; valid_input = 1'b1; reset = 1'b1;
        tick();
        vec++;
        if (ready_m !== 1'b1 || valid_m !== 1'b0) begin
            errs++;
            $display("FAIL reset_first_edge: got ready=%b valid=%b, want 1/0", ready_m, valid_m);
        end
        tick();
        valid_input = 1'b0;
        vec++;
        if (valid_m !== 1'b0) begin
            errs++;
            $display("FAIL no_accept_first_edge: got valid=%b, want 0", valid_m);
        end
        tick();
        vec++;
        if (valid_m !== 1'b1 || data_m !== 8'hCA) begin
            errs++;
            $display("FAIL reset_pre_b0: got %b/%h, want 1/ca", valid_m, data_m);
        end
        tick();
        vec++;
        if (valid_m !== 1'b1 || data_m !== 8'hFE) begin
            errs++;
            $display("FAIL reset_pre_b1: got %b/%h, want 1/fe", valid_m, data_m);
        end
        #3 reset = 1'b0;
        #1;
        vec++;
        if (data_m !== 8'h00 || valid_m !== 1'b0 || ready_m !== 1'b0) begin
            errs++;
            $display("FAIL reset_async: got data=%h valid=%b ready=%b, want 00/0/0", data_m, valid_m, ready_m);
        end
        repeat (2) tick();
        reset = 1'b1;
        tick();
        vec++;
        if (ready_m !== 1'b1) begin
            errs++;
            $display("FAIL reset_release_ready: got %b, want 1", ready_m);
        end
        clear_mon();
        repeat (8) tick();
        vec++;
        if (mq.size() != 0) begin
            errs++;
            $display("FAIL reset_stale_bytes: got %0d bytes, want 0", mq.size());
        end
    endtask

    task automatic test_single;
        logic [7:0] exp [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        data_input = 32'hDEADBEEF; valid_input = 1'b1;
        tick();
        valid_input = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            vec++;
            if (valid_m !== 1'b1 || data_m !== exp[i]) begin
                errs++;
                $display("FAIL single_b%0d: got %b/%h, want 1/%h", i, valid_m, data_m, exp[i]);
            end
        end
        tick();
        vec++;
        if (valid_m !== 1'b0 || data_m !== 8'h00) begin
            errs++;
            $display("FAIL single_idle: got %b/%h, want 0/00", valid_m, data_m);
        end
    endtask

    task automatic test_lsb_first;
        logic [7:0] exp [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        data_input = 32'hDEADBEEF; valid_input = 1'b1;
        tick();
        valid_input = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            vec++;
            if (valid_l !== 1'b1 || data_l !== exp[i]) begin
                errs++;
                $display("FAIL lsb_b%0d: got %b/%h, want 1/%h", i, valid_l, data_l, exp[i]);
            end
        end
        tick();
        vec++;
        if (valid_l !== 1'b0 || data_l !== 8'h00) begin
            errs++;
            $display("FAIL lsb_idle: got %b/%h, want 0/00", valid_l, data_l);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        logic       rexp;
        data_input = 32'h11223344; valid_input = 1'b1;
        tick();
        data_input = 32'h55667788;
        tick();
        valid_input = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick();
            rexp = (i >= 3);
            vec++;
            if (valid_m !== 1'b1 || data_m !== exp[i] || ready_m !== rexp) begin
                errs++;
                $display("FAIL b2b_b%0d: got %b/%h ready=%b, want 1/%h ready=%b",
                         i, valid_m, data_m, ready_m, exp[i], rexp);
            end
        end
        tick();
        vec++;
        if (valid_m !== 1'b0 || data_m !== 8'h00) begin
            errs++;
            $display("FAIL b2b_idle: got %b/%h, want 0/00", valid_m, data_m);
        end
    endtask

    task automatic test_stall;
        logic [31:0] words [3] = '{32'hA1A2A3A4, 32'hB1B2B3B4, 32'hC1C2C3C4};
        logic [7:0]  eb;
        logic        rdy;
        int          t, stall2;
        clear_mon();
        stall2 = 0;
        for (int w = 0; w < 3; w++) begin
            data_input = words[w]; valid_input = 1'b1;
            t = 0;
            do begin
                rdy = ready_m;
                tick();
                if (!rdy && w == 2) stall2++;
                t++;
            end while (!rdy && t < 20);
            if (!rdy) begin
                vec++; errs++;
                $display("FAIL stall_timeout: word %0d not accepted, want accepted within 20 cycles", w);
            end
        end
        valid_input = 1'b0;
        vec++;
        if (stall2 != 3) begin
            errs++;
            $display("FAIL stall_wait: got %0d stall cycles, want 3", stall2);
        end
        t = 0;
        while (mq.size() < 12 && t < 40) begin tick(); t++; end
        repeat (3) tick();
        vec++;
        if (mq.size() != 12) begin
            errs++;
            $display("FAIL stall_count: got %0d bytes, want 12", mq.size());
        end
        for (int i = 0; i < 12 && i < mq.size(); i++) begin
            eb = 8'(words[i / 4] >> (8 * (3 - (i % 4))));
            vec++;
            if (mq[i] !== eb || mc[i] != mc[0] + i) begin
                errs++;
                $display("FAIL stall_b%0d: got %h at cycle %0d, want %h at cycle %0d",
                         i, mq[i], mc[i], eb, mc[0] + i);
            end
        end
    endtask

    task automatic test_loopback;
        logic [31:0] sent[$];
        logic [31:0] w;
        logic        rdy;
        int          gap, t;
        clear_mon();
        for (int n = 0; n < 1000; n++) begin
            gap = int'($urandom_range(0, 3));
            if (gap > 0) begin
                valid_input = 1'b0;
                repeat (gap) tick();
            end
            w = $urandom;
            sent.push_back(w);
            data_input = w; valid_input = 1'b1;
            t = 0;
            do begin
                rdy = ready_m;
                tick();
                t++;
            end while (!rdy && t < 20);
            if (!rdy) begin
                vec++; errs++;
                $display("FAIL loop_timeout: word %0d not accepted, want accepted within 20 cycles", n);
            end
        end
        valid_input = 1'b0;
        t = 0;
        while ((pk_m.size() < 1000 || pk_l.size() < 1000) && t < 100) begin tick(); t++; end
        vec++;
        if (pk_m.size() != 1000 || pk_l.size() != 1000) begin
            errs++;
            $display("FAIL loop_count: got %0d/%0d words, want 1000/1000", pk_m.size(), pk_l.size());
        end
        for (int i = 0; i < 1000; i++) begin
            if (i < pk_m.size()) begin
                vec++;
                if (pk_m[i] !== sent[i]) begin
                    errs++;
                    $display("FAIL loop_msb_w%0d: got %h, want %h", i, pk_m[i], sent[i]);
                end
            end
            if (i < pk_l.size()) begin
                vec++;
                if (pk_l[i] !== sent[i]) begin
                    errs++;
                    $display("FAIL loop_lsb_w%0d: got %h, want %h", i, pk_l[i], sent[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        tick();
        test_lsb_first();
        test_loopback();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
